mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between the fetch stage (IF) and the load/store stage (DM) of the pipelined RISC-V core.
- Replaces clock-phase multiplexing with cycle-based arbitration against a synchronous memory port with 1-cycle read latency.
- Issues at most one memory access per cycle, returns read data to the right requester, and produces the IF/DM stall signals for the hazard unit.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_align_check.sv | 20 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory port.
package mem_pkg;

    // RISC-V load/store width and sign codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte address where the data region starts in the unified memory map
    localparam int unsigned DATA_MEM_BASE = 32'h0000_2000;

    // Which requester the read data returning next cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_align_check.sv
// Flags data accesses whose address is not naturally aligned to the access width.
module mem_align_check
    import mem_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       misalign_c
);

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned
    always_comb begin
        misalign_c = 1'b0;
        case (funct3)
            F3_H, F3_HU: misalign_c = addr_lo[0];
            F3_W:        misalign_c = (addr_lo != 2'b00);
            default:     misalign_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Cycle-based arbiter sharing one synchronous memory port between fetch and load/store.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = 14,
    parameter int unsigned MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_misalign,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_sel_data,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_dm
);

    localparam int unsigned          STREAK_W   = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              owner_q, owner_d;
    logic [31:0]         if_rdata_q, dm_rdata_q;
    logic                dm_win_c, if_win_c, dm_misalign_c;

    mem_align_check u_align (
        .funct3     (dm_funct3),
        .addr_lo    (dm_addr[1:0]),
        .misalign_c (dm_misalign_c)
    );

    // Pick the winner: DM has priority until it has starved IF for MAX_DM_STREAK cycles
    always_comb begin
        dm_win_c = 1'b0;
        if_win_c = 1'b0;
        if (rst_n) begin
            dm_win_c = dm_req && (!if_req || (streak_q < STREAK_MAX));
            if_win_c = if_req && !dm_win_c;
        end
    end

    // Drive the memory port from the winner; a misaligned DM grant issues nothing
    always_comb begin
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        mem_funct3   = 3'b000;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (dm_win_c && !dm_misalign_c) begin
            mem_en       = 1'b1;
            mem_we       = dm_we;
            mem_sel_data = 1'b1;
            mem_funct3   = dm_funct3;
            mem_addr     = dm_addr;
            mem_wdata    = dm_wdata;
        end else if (if_win_c) begin
            mem_en     = 1'b1;
            mem_funct3 = F3_W;
            mem_addr   = if_addr;
        end
    end

    // Grants, misalignment pulse and hazard-unit stalls
    assign if_gnt      = if_win_c;
    assign dm_gnt      = dm_win_c;
    assign dm_misalign = dm_win_c && dm_misalign_c;
    assign stall_if    = rst_n && if_req && !if_win_c;
    assign stall_dm    = rst_n && dm_req && !dm_win_c;

    // Route returning read data to its owner; hold the last word otherwise
    assign if_rvalid = (owner_q == OWN_IF);
    assign dm_rvalid = (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

    // Next streak count and next response owner
    always_comb begin
        streak_d = streak_q;
        owner_d  = OWN_NONE;
        if (!if_req || if_win_c) begin
            streak_d = '0;
        end else if (dm_win_c && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
        if (if_win_c) begin
            owner_d = OWN_IF;
        end else if (dm_win_c && !dm_misalign_c && !dm_we) begin
            owner_d = OWN_DM;
        end
    end

    // State registers; reset drops any outstanding response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q   <= '0;
            owner_q    <= OWN_NONE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
            if (owner_q == OWN_IF) begin
                if_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_DM) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned ADDR_W = 14;
    localparam int          MAXS   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req = 1'b0, dm_we = 1'b0;
    logic [2:0]        dm_funct3 = 3'b010;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [31:0]       dm_wdata = '0;
    logic              dm_gnt, dm_rvalid, dm_misalign;
    logic [31:0]       dm_rdata;
    logic              mem_en, mem_we, mem_sel_data;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    bit   [31:0]       mem_rdata;
    logic              stall_if, stall_dm;

    bit [31:0] imem [0:4095];
    bit [31:0] dmem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_streak = 0;
    int          m_pend   = 0;   // 0 none, 1 fetch response, 2 load response
    logic [31:0] m_pdata  = '0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DM_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign),
        .mem_en(mem_en), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
    );

    always #5 clk = ~clk;

    // Synchronous memory with 1-cycle read latency, split into two regions
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (mem_sel_data) dmem[mem_addr[13:2]] <= mem_wdata;
            end else begin
                mem_rdata <= mem_sel_data ? dmem[mem_addr[13:2]] : imem[mem_addr[13:2]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, check outputs against the model, advance the model
    task automatic step(input logic ifr, input logic [13:0] ifa, input logic dmr, input logic we,
                        input logic [2:0] f3, input logic [13:0] dma, input logic [31:0] wd);
        bit dm_w, if_w, mis, acc, st;
        @(negedge clk);
        if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = we;
        dm_funct3 = f3; dm_addr = dma; dm_wdata = wd;
        #2;
        if (m_pend == 1) m_if_rdata = m_pdata;
        if (m_pend == 2) m_dm_rdata = m_pdata;
        check_eq("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
        check_eq("dm_rvalid", 32'(dm_rvalid), 32'(m_pend == 2));
        check_eq("if_rdata", if_rdata, m_if_rdata);
        check_eq("dm_rdata", dm_rdata, m_dm_rdata);

        dm_w = dmr && (!ifr || m_streak < MAXS);
        if_w = ifr && !dm_w;
        mis  = dm_w && (((f3 % 4) == 1 && dma[0]) || (f3 == 3'd2 && dma[1:0] != 2'd0));
        acc  = if_w || (dm_w && !mis);
        st   = dm_w && !mis && we;
        check_eq("if_gnt", 32'(if_gnt), 32'(if_w));
        check_eq("dm_gnt", 32'(dm_gnt), 32'(dm_w));
        check_eq("dm_misalign", 32'(dm_misalign), 32'(mis));
        check_eq("mem_en", 32'(mem_en), 32'(acc));
        check_eq("mem_we", 32'(mem_we), 32'(st));
        check_eq("stall_if", 32'(stall_if), 32'(ifr && !if_w));
        check_eq("stall_dm", 32'(stall_dm), 32'(dmr && !dm_w));
        if (acc) begin
            check_eq("mem_sel_data", 32'(mem_sel_data), 32'(!if_w));
            check_eq("mem_addr", 32'(mem_addr), 32'(if_w ? ifa : dma));
            check_eq("mem_funct3", 32'(mem_funct3), 32'(if_w ? 3'b010 : f3));
        end
        if (st) check_eq("mem_wdata", mem_wdata, wd);

        m_pend  = if_w ? 1 : ((dm_w && !mis && !we) ? 2 : 0);
        m_pdata = if_w ? imem[ifa[13:2]] : dmem[dma[13:2]];
        if (!ifr || if_w) m_streak = 0;
        else if (dm_w && m_streak < MAXS) m_streak++;
    endtask

    task automatic idle();
        step(1'b0, 14'd0, 1'b0, 1'b0, 3'b010, 14'd0, 32'd0);
    endtask

    // All outputs must read zero while reset is asserted
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_misalign,
                                     mem_en, mem_we, mem_sel_data, stall_if, stall_dm}), 32'd0);
        check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
        check_eq({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        check_eq({tag, "_mem_bus"}, 32'({mem_funct3, mem_addr}), 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3_tab [5];
        logic [13:0] ra;
        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int i = 0; i < 4096; i++) imem[i] = $urandom;
        imem[1] = 32'h0000_2083;

        // Reset with both requesters active: everything must stay quiet
        if_req = 1'b1; dm_req = 1'b1; dm_addr = 14'd4;
        #3;
        check_reset_outputs("rst0");
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single fetch from 0x004
        step(1'b1, 14'h004, 1'b0, 1'b0, F3_W, 14'd0, 32'd0);
        check_eq("t1_if_gnt", 32'(if_gnt), 32'd1);
        idle();
        check_eq("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("t1_if_rdata", if_rdata, 32'h0000_2083);

        // Contention: DM wins three times, then IF is forced through
        idle();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 14'h010, 1'b1, 1'b0, F3_W, 14'h020, 32'd0);
            check_eq("t2_dm_gnt", 32'(dm_gnt), 32'(i < 3));
            check_eq("t2_if_gnt", 32'(if_gnt), 32'(i == 3));
            check_eq("t2_stall_if", 32'(stall_if), 32'(i < 3));
        end
        idle();

        // Store then load back the same word
        step(1'b0, 14'd0, 1'b1, 1'b1, F3_W, 14'h000, 32'hDEAD_BEEF);
        check_eq("t3_mem_we", 32'(mem_we), 32'd1);
        check_eq("t3_mem_sel_data", 32'(mem_sel_data), 32'd1);
        step(1'b0, 14'd0, 1'b1, 1'b0, F3_W, 14'h000, 32'd0);
        idle();
        check_eq("t3_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check_eq("t3_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

        // Misaligned halfword rejected, fetch proceeds next cycle
        step(1'b0, 14'd0, 1'b1, 1'b0, F3_H, 14'h003, 32'd0);
        check_eq("t4_dm_misalign", 32'(dm_misalign), 32'd1);
        check_eq("t4_mem_en", 32'(mem_en), 32'd0);
        step(1'b1, 14'h008, 1'b0, 1'b0, F3_W, 14'd0, 32'd0);
        check_eq("t4_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check_eq("t4_if_gnt", 32'(if_gnt), 32'd1);
        idle();

        // Reset between a load grant and its response
        step(1'b0, 14'd0, 1'b1, 1'b0, F3_W, 14'h000, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        m_pend = 0; m_streak = 0; m_if_rdata = '0; m_dm_rdata = '0;
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check_eq("t5_if_rvalid", 32'(if_rvalid), 32'd0);
        check_eq("t5_dm_rvalid", 32'(dm_rvalid), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            ra = 14'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            step($urandom_range(0, 99) < 75, 14'($urandom_range(0, 63) * 4),
                 $urandom_range(0, 99) < 65, $urandom_range(0, 2) == 0,
                 f3_tab[$urandom_range(0, 4)], ra, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
